// File: rtl/apu_codec_serializer_if.sv
// rtl/apu_codec_serializer_if.sv - mixer sample handshake and codec serial pins
interface apu_codec_serializer_if #(
    parameter int SAMPLE_BITS = 16
);
    logic [SAMPLE_BITS-1:0] dac_sample;
    logic                   adc_dat;
    logic                   sample_req;
    logic                   sample_end;
    logic [SAMPLE_BITS-1:0] adc_sample;
    logic                   bclk;
    logic                   lrclk;
    logic                   dac_dat;

    modport master (
        output dac_sample, adc_dat,
        input  sample_req, sample_end, adc_sample, bclk, lrclk, dac_dat
    );

    modport slave (
        input  dac_sample, adc_dat,
        output sample_req, sample_end, adc_sample, bclk, lrclk, dac_dat
    );
endinterface

// File: rtl/apu_codec_serializer.sv
// rtl/apu_codec_serializer.sv - mono codec serializer, left-justified (PAPU_I2S_MODE_EN: Philips I2S)
module apu_codec_serializer #(
    parameter int BCLK_DIV    = 4,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    apu_codec_serializer_if.slave bus
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    // Bit position of the left MSB within the 32-bit frame.
`ifdef PAPU_I2S_MODE_EN
    localparam logic [4:0] DATA_OFS = 5'd1;
`else
    localparam logic [4:0] DATA_OFS = 5'd0;
`endif

    logic [DIV_W-1:0]       r_div_cnt;
    logic [4:0]             r_bit_cnt;
    logic                   r_bclk;
    logic                   r_lrclk;
    logic                   r_dac_dat;
    logic                   r_sample_req;
    logic                   r_sample_end;
    logic [SAMPLE_BITS-1:0] r_tx_word;
    logic [SAMPLE_BITS-2:0] r_rx_shift;
    logic [SAMPLE_BITS-1:0] r_adc_sample;

    logic                   w_tick;
    logic [4:0]             w_next_bit;
    logic [3:0]             w_tx_idx;
    logic [4:0]             w_rx_pos;
    logic                   w_latch;
    logic [SAMPLE_BITS-1:0] w_rx_next;

    assign w_tick     = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    assign w_next_bit = r_bit_cnt + 5'd1;
    assign w_tx_idx   = ~(w_next_bit[3:0] - DATA_OFS[3:0]);
    assign w_rx_pos   = r_bit_cnt - DATA_OFS;
    assign w_latch    = (w_next_bit == DATA_OFS);
    assign w_rx_next  = {r_rx_shift, bus.adc_dat};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_bclk       <= 1'b0;
            r_lrclk      <= 1'b0;
            r_dac_dat    <= 1'b0;
            r_sample_req <= 1'b0;
            r_sample_end <= 1'b0;
            r_tx_word    <= '0;
            r_rx_shift   <= '0;
            r_adc_sample <= '0;
        end else begin
            r_sample_req <= 1'b0;
            r_sample_end <= 1'b0;
            if (w_tick) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
                if (r_bclk) begin
                    // Falling edge: advance to the next bit and present its data.
                    r_bit_cnt <= w_next_bit;
                    r_lrclk   <= w_next_bit[4];
                    if (w_latch) begin
                        r_tx_word    <= bus.dac_sample;
                        r_dac_dat    <= bus.dac_sample[SAMPLE_BITS-1];
                        r_sample_req <= 1'b1;
                    end else begin
                        r_dac_dat <= r_tx_word[w_tx_idx];
                    end
                end else if (!w_rx_pos[4]) begin
                    r_rx_shift <= w_rx_next[SAMPLE_BITS-2:0];
                    if (w_rx_pos[3:0] == 4'd15) begin
                        r_adc_sample <= w_rx_next;
                        r_sample_end <= 1'b1;
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign bus.bclk       = r_bclk;
    assign bus.lrclk      = r_lrclk;
    assign bus.dac_dat    = r_dac_dat;
    assign bus.sample_req = r_sample_req;
    assign bus.sample_end = r_sample_end;
    assign bus.adc_sample = r_adc_sample;
endmodule

// File: tb/tb_apu_codec_serializer.sv
// tb/tb_apu_codec_serializer.sv - randomized bench against a frame-timing reference model
module tb_apu_codec_serializer;
    localparam int D  = 4;
    localparam int D2 = 2;
`ifdef PAPU_I2S_MODE_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    apu_codec_serializer_if bus  ();
    apu_codec_serializer_if bus2 ();

    apu_codec_serializer #(.BCLK_DIV(D), .SAMPLE_BITS(16)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    apu_codec_serializer #(.BCLK_DIV(D2), .SAMPLE_BITS(16)) dut2 (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus2.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state: n = clk edges since reset released.
    int          n = 0;
    int          cyc = 0;
    logic [15:0] m_word = '0;
    logic [15:0] m_shift = '0;
    logic [15:0] m_adc = '0;
    logic        m_req = 1'b0;
    logic        m_end = 1'b0;
    logic        m_dac = 1'b0;
    int          first_req = -1;
    int          last_req = -1;
    int          last_req2 = -1;

    task automatic step();
        int bc, pos, p;
        @(posedge clk);
        cyc++;
        m_req = 1'b0;
        m_end = 1'b0;
        if (reset) begin
            n = 0; m_word = '0; m_shift = '0; m_adc = '0;
            last_req = -1; last_req2 = -1;
        end else begin
            n++;
            bc = (n / (2 * D)) % 32;
            if (n % (2 * D) == 0) begin
                if (bc == OFS) begin
                    m_word = bus.dac_sample;
                    m_req  = 1'b1;
                end
            end else if (n % (2 * D) == D) begin
                pos = (bc - OFS) & 31;
                if (pos < 16) begin
                    m_shift = {m_shift[14:0], bus.adc_dat};
                    if (pos == 15) begin
                        m_adc = m_shift;
                        m_end = 1'b1;
                    end
                end
            end
        end
        bc    = (n / (2 * D)) % 32;
        p     = (bc - OFS) & 31;
        m_dac = m_word[15 - (p % 16)];
        #1;
        check("bclk",       32'(bus.bclk),       32'((n / D) % 2));
        check("lrclk",      32'(bus.lrclk),      32'(bc >= 16));
        check("dac_dat",    32'(bus.dac_dat),    32'(m_dac));
        check("sample_req", 32'(bus.sample_req), 32'(m_req));
        check("sample_end", 32'(bus.sample_end), 32'(m_end));
        check("adc_sample", 32'(bus.adc_sample), 32'(m_adc));
        if (m_req && first_req < 0) first_req = n;
        if (bus.sample_req) begin
            if (last_req >= 0) check("req_period_div4", 32'(cyc - last_req), 32'd256);
            last_req = cyc;
        end
        if (bus2.sample_req) begin
            if (last_req2 >= 0) check("req_period_div2", 32'(cyc - last_req2), 32'd128);
            last_req2 = cyc;
        end
    endtask

    // mode 0: held word, random adc; 1: loopback stepping list; 2: fully random
    task automatic run(input int cycles, input int mode);
        logic [15:0] list [4];
        int idx;
        list[0] = 16'h0001; list[1] = 16'h8000; list[2] = 16'hFFFF; list[3] = 16'h8001;
        idx = 0;
        if (mode == 1) bus.dac_sample = list[0];
        for (int i = 0; i < cycles; i++) begin
            step();
            case (mode)
                0: bus.adc_dat = 1'($urandom);
                1: begin
                    if (m_req) idx++;
                    bus.dac_sample = list[idx % 4];
                    bus.adc_dat    = m_dac;
                end
                default: begin
                    bus.dac_sample = 16'($urandom);
                    bus.adc_dat    = 1'($urandom);
                end
            endcase
        end
    endtask

    initial begin
        bit found;
        bus.dac_sample  = 16'hA5C3;
        bus.adc_dat     = 1'b0;
        bus2.dac_sample = 16'h0000;
        bus2.adc_dat    = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        run(3 * 64 * D, 0);
        check("first_req_clk", 32'(first_req), (OFS != 0) ? 32'(2 * D) : 32'(64 * D));
        run(5 * 64 * D, 1);
        run(4 * 64 * D, 2);

        found = 1'b0;
        for (int i = 0; i < 64 * D && !found; i++) begin
            if (((n / (2 * D)) % 32) == 20) found = 1'b1;
            else run(1, 2);
        end
        check("reach_bit20", 32'(found), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_adc", 32'(bus.adc_sample), 32'd0);
        run(4 * 64 * D, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
